move_input_decoder: RTL and testbench

Input-side front end of the Connect-4 datapath: turns the raw column switches and drop button into one validated, handshaked move request per button press. Synchronises and debounces all five raw inputs, latches the selected column on the press edge, and rejects illegal moves (bad switch pattern, full column, game not running). Sits between the board pins (Switch_0..3, BTN_EAST) and the column-calculation logic, which it feeds through a valid/ready handshake.

---
 rtl/connect4_pkg.sv | 35 +++
 rtl/move_input_decoder_if.sv | 19 +
 rtl/input_debouncer.sv | 40 ++++
 rtl/move_input_decoder.sv | 120 ++++++++++++
 tb/tb_move_input_decoder.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/connect4_pkg.sv
// Shared types and constants for the Connect-4 input front end.
// Holds the decoder state encoding, reject reasons and the switch helpers.
package connect4_pkg;

  localparam int NUM_COLS = 4;
  localparam int ROWS     = 4;

  typedef enum logic [1:0] {
    ST_WAIT_RELEASE = 2'd0,
    ST_IDLE         = 2'd1,
    ST_CHECK        = 2'd2,
    ST_PRESENT      = 2'd3
  } dec_state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_ONEHOT   = 2'b01;
  localparam logic [1:0] ERR_FULL     = 2'b10;
  localparam logic [1:0] ERR_INACTIVE = 2'b11;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] encode4(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/move_input_decoder_if.sv
// Move request handshake between the input decoder and the column logic.
// The decoder is the master; the consumer drives only move_ready.
interface move_if;
  logic       move_valid;
  logic [1:0] move_col;
  logic       move_ready;
  logic       move_err;
  logic [1:0] err_code;

  modport master (
    output move_valid, move_col, move_err, err_code,
    input  move_ready
  );

  modport slave (
    input  move_valid, move_col, move_err, err_code,
    output move_ready
  );
endinterface

// File: rtl/input_debouncer.sv
// Two-flop synchroniser plus stability counter for one raw board input.
// quiet is high when the input pipeline holds no pending change.
module input_debouncer #(
  parameter  int DEBOUNCE_CYCLES = 16,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db,
  output logic quiet
);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      cnt    <= '0;
      db     <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      if (sync_2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt <= '0;
        db  <= sync_2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign quiet = (sync_1 == db) && (sync_2 == db) && (cnt == '0);

endmodule

// File: rtl/move_input_decoder.sv
// Turns debounced column switches and drop button into one checked move request per press.
//
//   state           | meaning
//   ----------------+------------------------------------------------------
//   ST_WAIT_RELEASE | button must be released and all inputs settled
//   ST_IDLE         | armed; press edge latches switches and game status
//   ST_CHECK        | judge latched move, raise error or present it
//   ST_PRESENT      | move_valid high until the consumer takes it
module move_input_decoder
  import connect4_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_raw,
  input  logic [NUM_COLS-1:0] sw_raw,
  input  logic [NUM_COLS-1:0] col_full,
  input  logic                game_active,
  move_if.master              mv
);

  logic [4:0]          raw_vec;
  logic [4:0]          db_vec;
  logic [4:0]          quiet_vec;
  logic                btn_db;
  logic                btn_q;
  logic                press;
  logic                settled;
  logic                armed;
  logic [NUM_COLS-1:0] sw_lat;
  logic [NUM_COLS-1:0] full_lat;
  logic                active_lat;
  logic [1:0]          chk_code;
  logic                latch_en;
  logic                check_en;
  dec_state_t          state;
  dec_state_t          state_nxt;

  assign raw_vec = {btn_raw, sw_raw};

  for (genvar i = 0; i < 5; i++) begin : g_db
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_vec[i]),
      .db    (db_vec[i]),
      .quiet (quiet_vec[i])
    );
  end

  assign btn_db  = db_vec[4];
  assign press   = btn_db && !btn_q;
  assign settled = &quiet_vec;

  // armed holds off the first edge after reset, before the synchronisers
  // have seen a button that may be held through reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_q <= 1'b0;
      armed <= 1'b0;
      state <= ST_WAIT_RELEASE;
    end else begin
      btn_q <= btn_db;
      armed <= 1'b1;
      state <= state_nxt;
    end
  end

  always_comb begin
    chk_code = ERR_NONE;
    if (!active_lat)
      chk_code = ERR_INACTIVE;
    else if (!is_onehot4(sw_lat))
      chk_code = ERR_ONEHOT;
    else if (full_lat[encode4(sw_lat)])
      chk_code = ERR_FULL;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT_RELEASE: if (armed && !btn_db && settled) state_nxt = ST_IDLE;
      ST_IDLE:         if (press) state_nxt = ST_CHECK;
      ST_CHECK:        state_nxt = (chk_code == ERR_NONE) ? ST_PRESENT : ST_WAIT_RELEASE;
      ST_PRESENT:      if (mv.move_ready) state_nxt = ST_WAIT_RELEASE;
      default:         state_nxt = ST_WAIT_RELEASE;
    endcase
  end

  always_comb begin
    mv.move_valid = (state == ST_PRESENT);
    latch_en      = (state == ST_IDLE) && press;
    check_en      = (state == ST_CHECK);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_lat      <= '0;
      full_lat    <= '0;
      active_lat  <= 1'b0;
      mv.move_col <= 2'b00;
      mv.err_code <= ERR_NONE;
      mv.move_err <= 1'b0;
    end else begin
      mv.move_err <= check_en && (chk_code != ERR_NONE);
      if (latch_en) begin
        sw_lat     <= db_vec[3:0];
        full_lat   <= col_full;
        active_lat <= game_active;
      end
      if (check_en) begin
        mv.err_code <= chk_code;
        if (chk_code == ERR_NONE)
          mv.move_col <= encode4(sw_lat);
      end
    end
  end

endmodule

// File: tb/tb_move_input_decoder.sv
// Directed bench for move_input_decoder with a short debounce window.
// Table of single presses, then hand sequences for bounce, back-pressure and reset.
module tb_move_input_decoder;

  localparam int DB = 4;

  logic       clk;
  logic       rst_n;
  logic       btn_raw;
  logic [3:0] sw_raw;
  logic [3:0] col_full;
  logic       game_active;

  move_if mv ();

  move_input_decoder #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .btn_raw     (btn_raw),
    .sw_raw      (sw_raw),
    .col_full    (col_full),
    .game_active (game_active),
    .mv          (mv)
  );

  typedef struct {
    logic [3:0] sw;
    logic [3:0] full;
    logic       active;
    logic       exp_valid;
    logic [1:0] exp_col;
    logic [1:0] exp_code;
  } vec_t;

  vec_t vecs[10];
  vec_t v;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   xfers    = 0;
  int   valid_cycles = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && mv.move_valid && mv.move_ready) xfers <= xfers + 1;
    if (rst_n && mv.move_valid) valid_cycles <= valid_cycles + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_valid"}, 8'(mv.move_valid), 8'd0);
    check({name, "_col"},   8'(mv.move_col),   8'd0);
    check({name, "_err"},   8'(mv.move_err),   8'd0);
    check({name, "_code"},  8'(mv.err_code),   8'd0);
  endtask

  // Caller must leave the decoder idle with the button released.
  task automatic do_press(input vec_t p, input string name);
    int x0;
    x0          = xfers;
    mv.move_ready = 1'b1;
    sw_raw      = p.sw;
    col_full    = p.full;
    game_active = p.active;
    btn_raw     = 1'b1;
    ticks(DB + 3);
    check({name, "_early_valid"}, 8'(mv.move_valid), 8'd0);
    check({name, "_early_err"},   8'(mv.move_err),   8'd0);
    tick();
    check({name, "_valid"}, 8'(mv.move_valid), 8'(p.exp_valid));
    check({name, "_err"},   8'(mv.move_err),   8'(!p.exp_valid));
    check({name, "_code"},  8'(mv.err_code),   8'(p.exp_code));
    if (p.exp_valid) check({name, "_col"}, 8'(mv.move_col), 8'(p.exp_col));
    tick();
    check({name, "_after_valid"}, 8'(mv.move_valid), 8'd0);
    check({name, "_after_err"},   8'(mv.move_err),   8'd0);
    check({name, "_xfers"}, 8'(xfers - x0), 8'(p.exp_valid));
    btn_raw = 1'b0;
    ticks(3 * DB + 8);
    check({name, "_code_held"}, 8'(mv.err_code), 8'(p.exp_code));
  endtask

  initial begin
    int x0;
    int vc0;
    int held_ok;

    //          sw       full     act   valid col    code
    vecs[0] = '{4'b0100, 4'b0000, 1'b1, 1'b1, 2'b10, 2'b00};
    vecs[1] = '{4'b0110, 4'b0000, 1'b1, 1'b0, 2'b00, 2'b01};
    vecs[2] = '{4'b0001, 4'b0001, 1'b1, 1'b0, 2'b00, 2'b10};
    vecs[3] = '{4'b0001, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b11};
    vecs[4] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 2'b00, 2'b01};
    vecs[5] = '{4'b1000, 4'b0111, 1'b1, 1'b1, 2'b11, 2'b00};
    vecs[6] = '{4'b0110, 4'b1111, 1'b0, 1'b0, 2'b00, 2'b11};
    vecs[7] = '{4'b0011, 4'b0011, 1'b1, 1'b0, 2'b00, 2'b01};
    vecs[8] = '{4'b0010, 4'b1101, 1'b1, 1'b1, 2'b01, 2'b00};
    vecs[9] = '{4'b0001, 4'b1110, 1'b1, 1'b1, 2'b00, 2'b00};

    rst_n         = 1'b0;
    btn_raw       = 1'b0;
    sw_raw        = 4'b0000;
    col_full      = 4'b0000;
    game_active   = 1'b1;
    mv.move_ready = 1'b1;
    ticks(3);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    ticks(10);

    for (int i = 0; i < 10; i++) begin
      do_press(vecs[i], $sformatf("vec%0d", i));
    end

    // Short button bounces must not register; the stable press yields one move.
    sw_raw = 4'b0100;
    game_active = 1'b1;
    col_full = 4'b0000;
    mv.move_ready = 1'b1;
    ticks(DB + 4);
    x0  = xfers;
    vc0 = valid_cycles;
    for (int k = 0; k < 2; k++) begin
      btn_raw = 1'b1;
      ticks(3);
      btn_raw = 1'b0;
      ticks(3);
    end
    check("bounce_no_move", 8'(xfers - x0), 8'd0);
    btn_raw = 1'b1;
    ticks(4 * DB + 10);
    check("bounce_one_move", 8'(xfers - x0), 8'd1);
    check("bounce_valid_cycles", 8'(valid_cycles - vc0), 8'd1);
    btn_raw = 1'b0;
    ticks(3 * DB + 8);

    // Back-pressure: move held steady while switches and game status change.
    mv.move_ready = 1'b0;
    sw_raw = 4'b0100;
    btn_raw = 1'b1;
    x0 = xfers;
    ticks(DB + 4);
    check("hold_valid", 8'(mv.move_valid), 8'd1);
    check("hold_col", 8'(mv.move_col), 8'b10);
    sw_raw = 4'b1000;
    game_active = 1'b0;
    col_full = 4'b1111;
    held_ok = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!(mv.move_valid === 1'b1 && mv.move_col === 2'b10)) held_ok = 0;
    end
    check("hold_stable", 8'(held_ok), 8'd1);
    check("hold_no_xfer", 8'(xfers - x0), 8'd0);
    mv.move_ready = 1'b1;
    tick();
    check("hold_xfer", 8'(xfers - x0), 8'd1);
    check("hold_drop", 8'(mv.move_valid), 8'd0);
    game_active = 1'b1;
    col_full = 4'b0000;
    btn_raw = 1'b0;
    ticks(3 * DB + 8);

    // Button held across reset release must not issue a move.
    rst_n = 1'b0;
    btn_raw = 1'b1;
    sw_raw = 4'b0100;
    #1;
    check_idle_outputs("rst_held");
    ticks(3);
    rst_n = 1'b1;
    x0  = xfers;
    vc0 = valid_cycles;
    ticks(6 * DB + 16);
    check("rst_held_no_xfer", 8'(xfers - x0), 8'd0);
    check("rst_held_no_valid", 8'(valid_cycles - vc0), 8'd0);
    btn_raw = 1'b0;
    ticks(3 * DB + 8);
    v = '{4'b0100, 4'b0000, 1'b1, 1'b1, 2'b10, 2'b00};
    do_press(v, "fresh");

    // Reset during PRESENT clears outputs at once with no transfer.
    mv.move_ready = 1'b0;
    sw_raw = 4'b1000;
    btn_raw = 1'b1;
    ticks(DB + 4);
    check("mid_valid", 8'(mv.move_valid), 8'd1);
    check("mid_col", 8'(mv.move_col), 8'b11);
    x0 = xfers;
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_rst");
    check("mid_no_xfer", 8'(xfers - x0), 8'd0);
    mv.move_ready = 1'b1;
    ticks(2);
    check("mid_no_xfer_after", 8'(xfers - x0), 8'd0);
    rst_n = 1'b1;
    btn_raw = 1'b0;
    ticks(3 * DB + 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
